// File: rtl/tdm_demux8.sv
// tdm_demux8 -- receive end of the 8:1 time-division mux path.
//
// Walks a registered channel select across the upstream mux8to1, samples
// the serial line once per slot and reassembles the slots into a parallel
// word. A completed frame is published on y with a one-cycle valid pulse.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   frame-start request (honoured in IDLE and DONE only)
//   en        in   slot advance enable; 0 stalls sampling and select
//   d         in   serial data from the upstream mux output
//   sel       out  registered channel select to the upstream mux
//   ch_en     out  one-hot slot strobe, set only while sampling a slot
//   y         out  last completed frame, y[i] = bit sampled in slot i
//   valid     out  one-cycle pulse after a frame completes
//   busy      out  high while a frame is being shifted in
//   dbg_state out  current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: there is no backpressure. A frame is requested by start in
// IDLE/DONE; each SHIFT cycle with en=1 consumes one slot of d. valid is a
// single-cycle qualifier for y; y is stable at all other times.
module tdm_demux8 #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
  input  logic             d,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  ch_en,
  output logic [N_CH-1:0]  y,
  output logic             valid,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [N_CH-1:0]  r_shadow;
  logic [N_CH-1:0]  r_y;

  state_t           w_state_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [N_CH-1:0]  w_shadow_nxt;
  logic [N_CH-1:0]  w_y_nxt;
  logic [N_CH-1:0]  w_ch_en;
  logic             w_last_slot;

  assign w_last_slot = (r_sel == SEL_W'(N_CH - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_shadow_nxt = r_shadow;
    w_y_nxt      = r_y;
    w_ch_en      = '0;
    case (r_state)
      S_IDLE: begin
        w_sel_nxt = '0;
        if (start) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (en) begin
          w_ch_en[r_sel]      = 1'b1;
          w_shadow_nxt[r_sel] = d;
          if (w_last_slot) begin
            // The last slot goes straight into y alongside the shadow so the
            // frame is published in the cycle after its final sample.
            w_y_nxt     = w_shadow_nxt;
            w_sel_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_sel_nxt = r_sel + SEL_W'(1);
          end
        end
      end
      S_DONE: begin
        w_sel_nxt = '0;
        // start here chains a frame with no idle gap.
        w_state_nxt = start ? S_SHIFT : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_shadow <= '0;
      r_y      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_shadow <= w_shadow_nxt;
      r_y      <= w_y_nxt;
    end
  end

  assign sel       = r_sel;
  assign ch_en     = w_ch_en;
  assign y         = r_y;
  assign valid     = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tdm_demux8.sv
module tb_tdm_demux8;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       en    = 1'b0;
  logic       d_drv = 1'b0;
  logic       loop_mode = 1'b0;
  logic [7:0] loop_word = 8'h00;
  wire        d;
  logic [2:0] sel;
  logic [7:0] ch_en, y;
  logic       valid, busy;
  logic [1:0] dbg_state;

  // Upstream mux8to1 for loopback tests: the DUT select picks a bit.
  assign d = loop_mode ? loop_word[sel] : d_drv;

  tdm_demux8 #(.N_CH(8), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .en(en), .d(d),
    .sel(sel), .ch_en(ch_en), .y(y), .valid(valid), .busy(busy),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vld_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // Model: a frame is "active" with m_cnt slots already collected; the
  // collected bits are packed into a word only when all N have arrived.
  bit         m_active = 0;
  bit         m_done   = 0;
  int         m_cnt    = 0;
  bit         m_bits[N];
  logic [7:0] m_y      = 8'h00;
  logic [7:0] exp_q[$];

  initial begin
    for (int i = 0; i < N; i++) m_bits[i] = 1'b0;
  end

  always @(negedge clk) begin
    logic [7:0] e_ch;
    logic [7:0] got;
    // compare current outputs with the model
    e_ch = (m_active && en) ? 8'(1 << m_cnt) : 8'h00;
    chk("sel",   32'(sel),   m_active ? 32'(m_cnt) : 32'd0);
    chk("ch_en", 32'(ch_en), 32'(e_ch));
    chk("busy",  32'(busy),  32'(m_active));
    chk("valid", 32'(valid), 32'(m_done));
    chk("y",     32'(y),     32'(m_y));
    if (valid === 1'b1) begin
      vld_cyc = cyc;
      if (exp_q.size() == 0) chk("sb_unexpected_frame", 32'(y), 32'hFFFF_FFFF);
      else begin
        got = exp_q.pop_front();
        chk("sb_frame", 32'(y), 32'(got));
      end
    end
    // advance the model with the inputs of this cycle
    if (reset) begin
      m_active = 0; m_done = 0; m_cnt = 0; m_y = 8'h00;
      for (int i = 0; i < N; i++) m_bits[i] = 1'b0;
    end else if (m_active) begin
      m_done = 0;
      if (en) begin
        m_bits[m_cnt] = d;
        m_cnt++;
        if (m_cnt == N) begin
          m_y = 8'h00;
          for (int i = 0; i < N; i++) m_y = m_y + (8'(m_bits[i]) << i);
          exp_q.push_back(m_y);
          m_active = 0; m_done = 1; m_cnt = 0;
        end
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_active = 1; m_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic begin_frame(output int s);
    start = 1'b1;
    en    = 1'($urandom_range(0, 1));
    d_drv = 1'($urandom_range(0, 1));
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives slots 0..7 from word; optional stall before slot stall_at,
  // optional start pulse during slot 3, optional chained start in DONE.
  task automatic drive_slots(input logic [7:0] word, input int stall_at,
                             input int stall_len, input bit mid_start,
                             input bit b2b);
    for (int i = 0; i < N; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          en = 1'b0; start = 1'b0;
          d_drv = 1'($urandom_range(0, 1));
          #1;
          chk("stall_sel", 32'(sel), 32'(stall_at));
          chk("stall_ch_en", 32'(ch_en), 32'd0);
          @(posedge clk); #1;
        end
      end
      en = 1'b1;
      d_drv = word[i];
      start = (mid_start && i == 3);
      @(posedge clk); #1;
    end
    // DONE cycle
    start = b2b;
    en    = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'b0; en = 1'($urandom_range(0, 1)); d_drv = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ch_en", 32'(ch_en), 32'd0);
    idle_cycles(2);

    // basic frame 1,0,1,1,0,0,1,0 -> 8'h4D, valid at cycle 9
    begin_frame(s);
    drive_slots(8'h4D, N, 0, 1'b0, 1'b0);
    chk("t1_vld_cyc", 32'(vld_cyc - s), 32'd9);
    chk("t1_y", 32'(y), 32'h4D);
    chk("t1_busy_after", 32'(busy), 32'd0);
    idle_cycles(3);

    // stall 3 cycles at sel=4 -> valid at cycle 12
    begin_frame(s);
    drive_slots(8'h4D, 4, 3, 1'b0, 1'b0);
    chk("t2_vld_cyc", 32'(vld_cyc - s), 32'd12);
    chk("t2_y", 32'(y), 32'h4D);
    idle_cycles(2);

    // back-to-back 4D then A5 -> valid at 9 and 18
    begin_frame(s);
    drive_slots(8'h4D, N, 0, 1'b0, 1'b1);
    chk("t3_vld1_cyc", 32'(vld_cyc - s), 32'd9);
    chk("t3_y_hold", 32'(y), 32'h4D);
    chk("t3_busy_b2b", 32'(busy), 32'd1);
    drive_slots(8'hA5, N, 0, 1'b0, 1'b0);
    chk("t3_vld2_cyc", 32'(vld_cyc - s), 32'd18);
    chk("t3_y2", 32'(y), 32'hA5);
    idle_cycles(2);

    // start mid-frame is ignored
    begin_frame(s);
    drive_slots(8'h96, N, 0, 1'b1, 1'b0);
    chk("t4_vld_cyc", 32'(vld_cyc - s), 32'd9);
    chk("t4_y", 32'(y), 32'h96);
    idle_cycles(2);

    // reset at sel=5 after frame FF, then frame 3C
    begin_frame(s);
    drive_slots(8'hFF, N, 0, 1'b0, 1'b0);
    chk("t5_y_ff", 32'(y), 32'hFF);
    begin_frame(s);
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; d_drv = 1'b1;
      @(posedge clk); #1;
    end
    chk("t5_sel5", 32'(sel), 32'd5);
    reset = 1'b1; start = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("t5_rst_y", 32'(y), 32'd0);
    chk("t5_rst_sel", 32'(sel), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_valid", 32'(valid), 32'd0);
    idle_cycles(1);
    begin_frame(s);
    drive_slots(8'h3C, N, 0, 1'b0, 1'b0);
    chk("t5_y_3c", 32'(y), 32'h3C);
    idle_cycles(2);

    // loopback through the mux
    loop_mode = 1'b1;
    loop_word = 8'h3C;
    begin_frame(s);
    repeat (N + 1) begin en = 1'b1; @(posedge clk); #1; end
    chk("t6_loop_3c", 32'(y), 32'h3C);
    loop_word = 8'h81;
    begin_frame(s);
    repeat (N + 1) begin en = 1'b1; @(posedge clk); #1; end
    chk("t6_loop_81", 32'(y), 32'h81);
    loop_mode = 1'b0;
    idle_cycles(2);

    // randomized traffic, occasional reset
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 3) == 0);
      en    = ($urandom_range(0, 3) != 0);
      d_drv = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    reset = 1'b0; start = 1'b0; en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
Receive end of the team's 8:1 time-division mux path. Drives the channel select to an upstream mux8to1, samples the single serial line once per channel slot, and reassembles the frame into a parallel word. Emits a one-hot channel strobe (3-to-8 decode of the select) and a one-cycle frame-valid pulse. Sits between a mux8to1-based serializer and any parallel consumer.

Parameters:
N_CH, 8, number of channels per frame (power of two, >= 2)
SEL_W, 3, select width; must equal log2(N_CH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  frame-start request; honoured in IDLE and DONE only
en  input  1  slot advance enable; 0 stalls sampling and select
d  input  1  serial data from upstream mux output
sel  output  SEL_W  registered channel select to the upstream mux
ch_en  output  N_CH  one-hot strobe: ch_en[sel]=1 when state=SHIFT and en=1, else all 0
y  output  N_CH  last completed frame; y[i] = bit sampled in slot i
valid  output  1  high for exactly one cycle after a frame completes
busy  output  1  high while state=SHIFT

Behaviour:
- One clock domain, synchronous active-high reset. Reset values: state=IDLE, sel=0, y=0, valid=0, busy=0, ch_en=0, internal shadow register=0.
- FSM states IDLE, SHIFT, DONE, all registered.
- IDLE: sel=0. start=1 -> SHIFT. d is not sampled in the start cycle.
- SHIFT: busy=1. If en=1: shadow[sel] <= d.
  - If sel /= N_CH-1: sel <= sel+1.
  - If sel = N_CH-1: y <= shadow with bit N_CH-1 replaced by d; sel wraps to 0; go to DONE.
  - If en=0: sel, shadow and state hold; ch_en=0. Stalls have no length limit.
  - start is ignored in SHIFT.
- DONE: valid=1 for this single cycle; sel=0.
  - start=1 -> SHIFT. This is a back-to-back frame with no idle gap, and the first slot is sampled the next cycle.
  - Otherwise -> IDLE.
- Latency with en held high: start accepted at cycle 0, slots sampled at cycles 1..N_CH, y updated and valid=1 in cycle N_CH+1 (cycle 9 for N_CH=8).
- y changes only on frame completion. Partial frames never reach y. y holds its value indefinitely between frames.
- sel is a registered output, so the upstream mux sees sel one full cycle before d is sampled in that slot.
- ch_en is combinational from registered state, sel and en. It never has more than one bit set.
- Reset asserted in any state, including mid-SHIFT, wins over start and en. The next cycle is the reset state, and the partial frame and y are discarded (y=0).
- start and en are both high in the IDLE cycle: only start matters, and no sample is taken.

Test Plan:
- Reset, then start with en=1 and d slots 0..7 = 1,0,1,1,0,0,1,0 -> sel steps 0..7 in cycles 1..8; ch_en = 8'h01..8'h80; cycle 9: y=8'h4D, valid=1 for one cycle, busy=0 after.
- Same frame with en=0 for 3 cycles while sel=4 -> sel holds 4, ch_en=0 during the stall; y=8'h4D; valid at cycle 12.
- Back-to-back: frame 8'h4D, start=1 in the DONE cycle, next frame 8'hA5 -> valid pulses at cycles 9 and 18; y goes 8'h4D then 8'hA5; y holds 8'h4D during the second frame.
- start pulsed at sel=3 mid-frame -> no restart; sel continues 4..7; frame completes normally with the correct y.
- reset asserted at sel=5 after an earlier frame 8'hFF -> next cycle y=0, sel=0, valid=0, busy=0, state IDLE; a following frame 8'h3C completes correctly.
- Loopback: sel drives a mux8to1 select with inputs 8'h3C, start, en=1 -> y=8'h3C; repeat with inputs 8'h81 -> y=8'h81.
